// File: rtl/xtile_pkg.sv
// Shared types and helpers for the X-tile SRAM row movers (loader/storer).
package xtile_pkg;

    // Row storer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } storer_state_t;

    // Index width for a range of v entries; never narrower than one bit.
    function automatic int idx_w(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/xtile_row_storer.sv
// Drains one N-word result row into the k/n-addressed X SRAM, one lane per
// cycle, as a write master. Lanes can be masked off; an external arbiter may
// steal the port (x_stall), in which case the current write is retried.
module xtile_row_storer
    import xtile_pkg::*;
#(
    parameter int N      = 8,
    parameter int KMAX   = 1024,
    parameter int DATA_W = 32,
    parameter int BYTE_W = DATA_W / 8,
    parameter int N_W    = idx_w(N),
    parameter int K_W    = idx_w(KMAX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic [K_W-1:0]        row_k,
    input  logic [N*DATA_W-1:0]   row_data_flat,
    input  logic [N-1:0]          row_lane_en,
    output logic                  x_en,
    output logic                  x_re,
    output logic                  x_we,
    output logic [K_W-1:0]        x_k,
    output logic [N_W-1:0]        x_n,
    output logic [DATA_W-1:0]     x_wdata,
    output logic [BYTE_W-1:0]     x_wmask,
    input  logic                  x_stall,
    output logic                  busy,
    output logic                  row_done,
    output logic                  row_err
);

    storer_state_t          state, state_next;
    logic [N_W-1:0]         lane, lane_next;
    logic                   err, err_next;
    logic                   capture;
    logic                   writing;
    logic                   out_of_range;

    // Row payload: captured once per handshake, held frozen while busy.
    logic [K_W-1:0]         cur_k;
    logic [N*DATA_W-1:0]    cur_data;
    logic [N-1:0]           cur_lane_en;

    assign out_of_range = (int'(row_k) >= KMAX);

    // Control state: only the FSM, lane counter and error flag are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lane  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            lane  <= lane_next;
            err   <= err_next;
        end
    end

    // Payload capture on the accepting handshake; data path carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            cur_k       <= row_k;
            cur_data    <= row_data_flat;
            cur_lane_en <= row_lane_en;
        end
    end

    // Next-state logic: accept, walk lanes (skipping masked ones, holding on stall), finish.
    always_comb begin
        state_next = state;
        lane_next  = lane;
        err_next   = err;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (row_valid) begin
                    capture   = 1'b1;
                    lane_next = '0;
                    if (out_of_range) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        err_next   = 1'b0;
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                // A masked lane never touches the port, so a stall cannot hold it.
                if (!cur_lane_en[lane] || !x_stall) begin
                    if (lane == N_W'(N - 1)) begin
                        state_next = DONE;
                    end else begin
                        lane_next = lane + N_W'(1);
                    end
                end
            end
            DONE: begin
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs decode registered state only; x_stall never feeds an output.
    assign writing   = (state == WRITE) && cur_lane_en[lane];
    assign row_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign row_done  = (state == DONE) && !err;
    assign row_err   = (state == DONE) && err;
    assign x_en      = writing;
    assign x_we      = writing;
    assign x_re      = 1'b0;
    assign x_k       = writing ? cur_k : '0;
    assign x_n       = writing ? lane : '0;
    assign x_wdata   = writing ? cur_data[lane*DATA_W +: DATA_W] : '0;
    assign x_wmask   = writing ? '1 : '0;

endmodule

// File: tb/tb_xtile_row_storer.sv
// Directed bench for xtile_row_storer with a behavioural k/n SRAM model.
module tb_xtile_row_storer;

    localparam int N      = 8;
    localparam int KMAX   = 1000;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 4;
    localparam int N_W    = 3;
    localparam int K_W    = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 row_valid;
    logic                 row_ready;
    logic [K_W-1:0]       row_k;
    logic [N*DATA_W-1:0]  row_data_flat;
    logic [N-1:0]         row_lane_en;
    logic                 x_en, x_re, x_we;
    logic [K_W-1:0]       x_k;
    logic [N_W-1:0]       x_n;
    logic [DATA_W-1:0]    x_wdata;
    logic [BYTE_W-1:0]    x_wmask;
    logic                 x_stall;
    logic                 busy, row_done, row_err;

    logic [31:0] mem  [KMAX][N];
    int          wcnt [KMAX][N];
    int          en_cycles;
    int          done_cnt;
    int          pass_cnt;
    int          total_cnt;

    always #5 clk = ~clk;

    xtile_row_storer #(
        .N(N), .KMAX(KMAX), .DATA_W(DATA_W), .BYTE_W(BYTE_W), .N_W(N_W), .K_W(K_W)
    ) dut (
        .clk(clk), .rst(rst),
        .row_valid(row_valid), .row_ready(row_ready), .row_k(row_k),
        .row_data_flat(row_data_flat), .row_lane_en(row_lane_en),
        .x_en(x_en), .x_re(x_re), .x_we(x_we), .x_k(x_k), .x_n(x_n),
        .x_wdata(x_wdata), .x_wmask(x_wmask), .x_stall(x_stall),
        .busy(busy), .row_done(row_done), .row_err(row_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] bus_obs();
        return 64'({x_en, x_we, x_re, x_k, x_n, x_wdata, x_wmask});
    endfunction

    function automatic logic [63:0] bus_exp(input logic en, input logic [K_W-1:0] k,
                                            input logic [N_W-1:0] n, input logic [31:0] d);
        if (en) return 64'({1'b1, 1'b1, 1'b0, k, n, d, 4'hF});
        return 64'd0;
    endfunction

    // Finish the current cycle (SRAM model commits at the edge) and enter the next.
    task automatic adv();
        @(negedge clk);
        if (x_en === 1'b1 && x_we === 1'b1 && x_stall === 1'b0 && int'(x_k) < KMAX) begin
            mem[x_k][x_n]  = x_wdata;
            wcnt[x_k][x_n] = wcnt[x_k][x_n] + 1;
        end
        if (x_en === 1'b1) en_cycles++;
        if (row_done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input logic [K_W-1:0] k, input logic [31:0] base, input logic [N-1:0] en);
        row_k       = k;
        row_lane_en = en;
        for (int n = 0; n < N; n++) row_data_flat[n*DATA_W +: DATA_W] = base + 32'(n);
    endtask

    // Cycle 0 handshake, returns positioned in cycle 1 with row_valid dropped.
    task automatic start_row(input string tag, input logic [K_W-1:0] k, input logic [31:0] base,
                             input logic [N-1:0] en);
        set_row(k, base, en);
        row_valid = 1'b1;
        chk({tag, "_ready_c0"}, 64'(row_ready), 64'd1);
        adv();
        row_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] mask;
        int         lane;
        int         en0, done0;
        pass_cnt = 0; total_cnt = 0; en_cycles = 0; done_cnt = 0;
        rst = 1'b1; row_valid = 1'b0; row_k = '0; row_data_flat = '0;
        row_lane_en = '0; x_stall = 1'b0;
        for (int k = 0; k < KMAX; k++)
            for (int n = 0; n < N; n++) begin
                mem[k][n]  = 32'd0;
                wcnt[k][n] = 0;
            end
        repeat (3) adv();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 64'(row_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_err", 64'({row_done, row_err}), 64'd0);
        chk("rst_bus", bus_obs(), 64'd0);
        adv();

        // Basic row: k=5, all lanes
        start_row("basic", 10'd5, 32'h1000, 8'hFF);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("basic_bus_c%0d", c), bus_obs(), bus_exp(1'b1, 10'd5, 3'(c-1), 32'h1000 + 32'(c-1)));
            chk($sformatf("basic_ready_c%0d", c), 64'({row_ready, busy}), 64'b01);
            adv();
        end
        chk("basic_done_c9", 64'({row_done, row_err}), 64'b10);
        chk("basic_bus_c9", bus_obs(), 64'd0);
        adv();
        chk("basic_ready_c10", 64'({row_ready, row_done}), 64'b10);
        for (int n = 0; n < N; n++)
            chk($sformatf("basic_mem_n%0d", n), 64'(mem[5][n]), 64'(32'h1000 + 32'(n)));
        adv();

        // Stall in cycles 3-4 on lane 2
        for (int n = 0; n < N; n++) wcnt[5][n] = 0;
        start_row("stall", 10'd5, 32'h3000, 8'hFF);
        for (int c = 1; c <= 10; c++) begin
            x_stall = (c == 3 || c == 4);
            lane = (c <= 2) ? c - 1 : (c <= 5) ? 2 : c - 3;
            chk($sformatf("stall_bus_c%0d", c), bus_obs(), bus_exp(1'b1, 10'd5, 3'(lane), 32'h3000 + 32'(lane)));
            adv();
        end
        x_stall = 1'b0;
        chk("stall_done_c11", 64'({row_done, row_err}), 64'b10);
        adv();
        for (int n = 0; n < N; n++) begin
            chk($sformatf("stall_once_n%0d", n), 64'(wcnt[5][n]), 64'd1);
            chk($sformatf("stall_mem_n%0d", n), 64'(mem[5][n]), 64'(32'h3000 + 32'(n)));
        end

        // Lane mask A5 over preloaded k=7
        mask = 8'hA5;
        for (int n = 0; n < N; n++) mem[7][n] = 32'hDEAD;
        start_row("mask", 10'd7, 32'h4000, mask);
        for (int c = 1; c <= 8; c++) begin
            x_stall = (c == 2);  // stall on a masked lane must not hold it
            chk($sformatf("mask_bus_c%0d", c), bus_obs(), bus_exp(mask[c-1], 10'd7, 3'(c-1), 32'h4000 + 32'(c-1)));
            adv();
        end
        x_stall = 1'b0;
        chk("mask_done_c9", 64'({row_done, row_err}), 64'b10);
        adv();
        for (int n = 0; n < N; n++)
            chk($sformatf("mask_mem_n%0d", n), 64'(mem[7][n]), mask[n] ? 64'(32'h4000 + 32'(n)) : 64'h0000DEAD);

        // Out-of-range row_k = KMAX
        en0 = en_cycles;
        done0 = done_cnt;
        start_row("oor", 10'(KMAX), 32'h9000, 8'hFF);
        chk("oor_err_c1", 64'({row_err, row_done, busy}), 64'b101);
        chk("oor_bus_c1", bus_obs(), 64'd0);
        adv();
        chk("oor_ready_c2", 64'({row_ready, row_err}), 64'b10);
        chk("oor_no_en", 64'(en_cycles - en0), 64'd0);
        chk("oor_no_done", 64'(done_cnt - done0), 64'd0);

        // Back-to-back: row_valid held, k=1 then k=2
        set_row(10'd1, 32'h5000, 8'hFF);
        row_valid = 1'b1;
        chk("b2b_ready_c0", 64'(row_ready), 64'd1);
        adv();
        set_row(10'd2, 32'h6000, 8'hFF);  // must not disturb the row in flight
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("b2b_ready_c%0d", c), 64'(row_ready), 64'd0);
            if (c <= 8)
                chk($sformatf("b2b_bus1_c%0d", c), bus_obs(), bus_exp(1'b1, 10'd1, 3'(c-1), 32'h5000 + 32'(c-1)));
            else
                chk("b2b_done1_c9", 64'(row_done), 64'd1);
            adv();
        end
        chk("b2b_ready_c10", 64'(row_ready), 64'd1);
        adv();
        row_valid = 1'b0;
        for (int c = 11; c <= 18; c++) begin
            chk($sformatf("b2b_bus2_c%0d", c), bus_obs(), bus_exp(1'b1, 10'd2, 3'(c-11), 32'h6000 + 32'(c-11)));
            adv();
        end
        chk("b2b_done2_c19", 64'(row_done), 64'd1);
        adv();
        for (int n = 0; n < N; n++) begin
            chk($sformatf("b2b_mem1_n%0d", n), 64'(mem[1][n]), 64'(32'h5000 + 32'(n)));
            chk($sformatf("b2b_mem2_n%0d", n), 64'(mem[2][n]), 64'(32'h6000 + 32'(n)));
        end

        // Reset mid-row: lanes 0-2 land, then abort
        done0 = done_cnt;
        start_row("rstmid", 10'd9, 32'h7000, 8'hFF);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("rstmid_bus_c%0d", c), bus_obs(), bus_exp(1'b1, 10'd9, 3'(c-1), 32'h7000 + 32'(c-1)));
            if (c == 3) rst = 1'b1;
            adv();
        end
        rst = 1'b0;
        chk("rstmid_ready", 64'({row_ready, busy}), 64'b10);
        chk("rstmid_bus", bus_obs(), 64'd0);
        chk("rstmid_done_err", 64'({row_done, row_err}), 64'd0);
        repeat (10) adv();
        chk("rstmid_no_done", 64'(done_cnt - done0), 64'd0);
        for (int n = 0; n < N; n++) begin
            chk($sformatf("rstmid_mem_n%0d", n), 64'(mem[9][n]), (n < 3) ? 64'(32'h7000 + 32'(n)) : 64'd0);
            chk($sformatf("rstmid_cnt_n%0d", n), 64'(wcnt[9][n]), (n < 3) ? 64'd1 : 64'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/xtile_row_storer.md
# xtile_row_storer

- Drains one result row of N words, all sharing a common k index, into the k/n-addressed X SRAM, one word per cycle.
- Reverse direction of the SRAM-to-X-tile row loader: same SRAM port signals, driven as a write master instead of a read master.
- Sits between the attention-score datapath (row producer) and the X SRAM; an external arbiter may steal the SRAM port cycle-by-cycle via `x_stall`.

## Interface
- `N`, 8, words per row (lanes)
- `KMAX`, 1024, number of k rows in SRAM
- `DATA_W`, 32, word width
- `BYTE_W`, DATA_W/8, byte-mask width
- `N_W`, (N<=1)?1:$clog2(N), lane index width
- `K_W`, (KMAX<=1)?1:$clog2(KMAX), k index width
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `row_valid`  in  1  producer offers a row
- `row_ready`  out  1  storer can accept a row (high only in IDLE)
- `row_k`  in  K_W  destination k index
- `row_data_flat`  in  N*DATA_W  lane n = `[n*DATA_W +: DATA_W]`
- `row_lane_en`  in  N  per-lane write enable; 0 = lane skipped
- `x_en`, `x_re`, `x_we`  out  1 each  SRAM controls; `x_re` is tied 0
- `x_k`  out  K_W  SRAM row address
- `x_n`  out  N_W  SRAM lane address
- `x_wdata`  out  DATA_W  write data
- `x_wmask`  out  BYTE_W  byte mask; all ones when writing
- `x_stall`  in  1  SRAM port taken by another master this cycle; the write did not happen
- `busy`  out  1  FSM not in IDLE
- `row_done`  out  1  one-cycle pulse: row fully committed
- `row_err`  out  1  one-cycle pulse: `row_k` >= KMAX, row dropped

## Operation
- FSM states: IDLE, WRITE, DONE.
- **IDLE**
  - `row_ready`=1.
  - On `row_valid & row_ready`: register `row_k`, `row_data_flat` and `row_lane_en`; set n=0; go to WRITE.
  - If the captured `row_k` >= KMAX: go to DONE and flag the error. No SRAM access occurs.
- **WRITE**, per cycle at lane n:
  - If `lane_en[n]`=1: drive `x_en`=`x_we`=1, `x_k`=k, `x_n`=n, `x_wdata`=word n, `x_wmask`='1.
    - If `x_stall`=0: the write is committed and n advances.
    - If `x_stall`=1: hold n and all outputs, and retry next cycle.
  - If `lane_en[n]`=0: drive no write and advance n unconditionally. `x_stall` is ignored.
  - When n=N-1 advances, go to DONE. The lane counter never wraps inside a row.
- **DONE**
  - Pulse `row_done`, or `row_err` if the error flag is set (never both).
  - Return to IDLE.
- When not writing, `x_en`=`x_we`=0 and `x_k`, `x_n`, `x_wdata`, `x_wmask` are 0. `x_re` is always 0.
- Registered row data is frozen while busy; input changes while `row_ready`=0 are ignored.
- A row with all lanes disabled still walks N cycles, then pulses `row_done`.

## Timing
- Reset: state=IDLE, n=0.
  - Outputs after reset: `row_ready`=1; `busy`, `row_done`, `row_err`, `x_en`, `x_we`, `x_re`=0; `x_k`, `x_n`, `x_wdata`, `x_wmask`=0.
  - Reset mid-row aborts immediately; partially written lanes stay in SRAM. No `row_done` is issued.
- Handshake at cycle 0 gives the first write cycle at 1.
  - With no stalls, lane n is written in cycle n+1 and `row_done` is high in cycle N+1.
  - `row_ready` returns in cycle N+2. Throughput is one row per N+2 cycles.
- Each stalled cycle adds exactly one cycle.
- Out-of-range row: `row_err` in cycle 1, `row_ready` again in cycle 2.
- All outputs are registered or decoded from registered state only. No combinational path from `row_valid` to any SRAM output.

## Structure
- Shared package `xtile_pkg`: state enum `storer_state_t` {IDLE, WRITE, DONE}; the N_W/K_W width-function helper.
- No sub-modules. A separate top (`xtile_storer_top`) pairs this block with `sram_mem_kn` and the CPU-read arbiter that drives `x_stall`; that top is out of scope here.

## Test plan
- Basic row: k=5, data lane n = 0x1000+n, `lane_en`=8'hFF, N=8.
  - Writes (5,n) in cycles 1..8, `row_done` in cycle 9.
  - SRAM readback equals 0x1000..0x1007.
- Stall: as basic, `x_stall`=1 in cycles 3–4.
  - Lane 2 write is held for cycles 3–5 with identical outputs.
  - `row_done` in cycle 11; no lane written twice.
- Lane mask 8'hA5 on k=7, SRAM preloaded with 0xDEAD:
  - Only n=0,2,5,7 are written; other lanes read back 0xDEAD.
  - `row_done` in cycle 9.
- Out-of-range `row_k`=KMAX:
  - `x_en` never asserts.
  - `row_err` in cycle 1 with `row_done`=0; `row_ready` high in cycle 2.
- Back-to-back: `row_valid` held high with rows k=1 then k=2.
  - Second handshake in cycle 10.
  - Both rows correct; `row_ready` low in cycles 1..9.
- Reset in cycle 4 of a row:
  - Next cycle all outputs are at reset values and `row_ready`=1.
  - Lanes 0–2 written, lanes 3–7 untouched, no `row_done`.
